// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared constants, FSM state type and command helpers for remote_comm
package remote_comm_pkg;

    localparam int DEFAULT_BAUD_DIV = 434;

    localparam logic [7:0]  POS_ACK  = 8'hA5;
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [3:0]  OP_MOVE  = 4'h4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_HI = 2'd1,
        SEND_LO = 2'd2
    } tx_state_e;

    // Move command: opcode[15:12], heading[11:4], squares[3:0]
    function automatic logic [15:0] move_cmd(input logic [7:0] heading, input logic [3:0] squares);
        return {OP_MOVE, heading, squares};
    endfunction

endpackage

// File: rtl/remote_comm_uart_xcvr.sv
// rtl/remote_comm_uart_xcvr.sv - 8N1 UART transmitter and receiver with trmt/tx_done and rdy/clr_rdy handshakes
module uart_xcvr
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       tx_o,
    input  logic       trmt_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_done_o,
    input  logic       clr_rdy_i,
    output logic       rdy_o,
    output logic [7:0] rx_data_o
);

    localparam int CW = $clog2(BAUD_DIV + BAUD_DIV / 2);
    localparam logic [CW-1:0] BIT_LAST     = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FIRST_SAMPLE = CW'(BAUD_DIV + BAUD_DIV / 2 - 1);

    logic [9:0]    tx_shift_q;
    logic [CW-1:0] tx_baud_q;
    logic [3:0]    tx_bit_q;
    logic          tx_busy_q;

    assign tx_o      = tx_shift_q[0];
    assign tx_done_o = tx_busy_q && (tx_bit_q == 4'd9) && (tx_baud_q == BIT_LAST);

    // A trmt on the last stop-bit cycle reloads the shifter, giving back-to-back frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= '1;
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_busy_q  <= 1'b0;
        end else if (trmt_i) begin
            tx_shift_q <= {1'b1, tx_data_i, 1'b0};
            tx_baud_q  <= '0;
            tx_bit_q   <= '0;
            tx_busy_q  <= 1'b1;
        end else if (tx_busy_q) begin
            if (tx_baud_q == BIT_LAST) begin
                tx_baud_q  <= '0;
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                tx_bit_q   <= tx_bit_q + 4'd1;
                if (tx_done_o) tx_busy_q <= 1'b0;
            end else begin
                tx_baud_q <= tx_baud_q + CW'(1);
            end
        end
    end

    logic [1:0]    rx_sync_q;
    logic          rx_prev_q;
    logic          rx_busy_q;
    logic [CW-1:0] rx_cnt_q;
    logic [3:0]    rx_bit_q;
    logic [7:0]    rx_shift_q;
    logic [7:0]    rx_data_q;
    logic          rdy_q;
    logic          rx_s;

    assign rx_s      = rx_sync_q[1];
    assign rdy_o     = rdy_q;
    assign rx_data_o = rx_data_q;

    // The start-bit sample point is skipped: the first sample lands mid data bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_i};
            rx_prev_q <= rx_s;
            if (clr_rdy_i) rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (rx_prev_q && !rx_s) begin
                    rx_busy_q <= 1'b1;
                    rx_cnt_q  <= FIRST_SAMPLE;
                    rx_bit_q  <= '0;
                    rdy_q     <= 1'b0;
                end
            end else if (rx_cnt_q != '0) begin
                rx_cnt_q <= rx_cnt_q - CW'(1);
            end else if (rx_bit_q == 4'd8) begin
                rx_busy_q <= 1'b0;
                rx_data_q <= rx_shift_q;
                rdy_q     <= 1'b1;
            end else begin
                rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                rx_bit_q   <= rx_bit_q + 4'd1;
                rx_cnt_q   <= BIT_LAST;
            end
        end
    end

endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - sends a 16-bit command as two UART bytes (high first) and returns response bytes
module remote_comm
    import remote_comm_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        snd_cmd,
    output logic        cmd_snt,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    tx_state_e  state_q;
    logic [7:0] lo_byte_q;
    logic       cmd_snt_q;
    logic       accept;
    logic       trmt;
    logic       tx_done;
    logic [7:0] tx_data;

    // trmt is combinational so the start bit leaves on the cycle right after the accept.
    assign accept  = (state_q == IDLE) && snd_cmd;
    assign trmt    = accept || ((state_q == SEND_HI) && tx_done);
    assign tx_data = (state_q == IDLE) ? cmd[15:8] : lo_byte_q;
    assign cmd_snt = cmd_snt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lo_byte_q <= '0;
            cmd_snt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snd_cmd) begin
                        lo_byte_q <= cmd[7:0];
                        cmd_snt_q <= 1'b0;
                        state_q   <= SEND_HI;
                    end
                end
                SEND_HI: if (tx_done) state_q <= SEND_LO;
                SEND_LO: begin
                    if (tx_done) begin
                        cmd_snt_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    uart_xcvr #(.BAUD_DIV(BAUD_DIV)) u_xcvr (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (RX),
        .tx_o      (TX),
        .trmt_i    (trmt),
        .tx_data_i (tx_data),
        .tx_done_o (tx_done),
        .clr_rdy_i (accept),
        .rdy_o     (resp_rdy),
        .rx_data_o (resp)
    );

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - randomized self-checking bench for remote_comm against a frame-level model
module tb_remote_comm;
    import remote_comm_pkg::*;

    localparam int B       = DEFAULT_BAUD_DIV;
    localparam int FRAME20 = 20 * B;
    localparam int RDY_NOM = (19 * B) / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        snd_cmd = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        TX, cmd_snt, resp_rdy;
    logic [7:0]  resp;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .TX       (TX),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Model state: transmit frame timing, expected byte stream, receive frame timing
    int          cyc = 0;
    bit          tx_valid = 1'b0;
    int          tx_e = 0;
    logic [19:0] tx_frame = '1;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    bit          rx_valid = 1'b0;
    int          rx_s = 0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  rx_prev = 8'h00;
    int          rise_cnt = 0;
    logic        prev_snt = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            tx_valid = 1'b0;
            exp_q.delete();
        end else if (snd_cmd && !(tx_valid && cyc <= tx_e + FRAME20)) begin
            tx_valid = 1'b1;
            tx_e     = cyc;
            tx_frame = {1'b1, cmd[7:0], 1'b0, 1'b1, cmd[15:8], 1'b0};
            exp_q.push_back(cmd[15:8]);
            exp_q.push_back(cmd[7:0]);
        end
    end

    always @(negedge clk) begin
        logic       exp_tx, exp_snt, exp_rdy;
        logic [7:0] exp_resp;
        bit         skip_rdy, skip_resp;
        int         d;
        if (!rst_n) begin
            chk("rst_tx", TX, 1);
            chk("rst_cmd_snt", cmd_snt, 0);
            chk("rst_resp_rdy", resp_rdy, 0);
            chk("rst_resp", resp, 0);
        end else begin
            exp_tx = 1'b1;
            if (tx_valid && cyc >= tx_e && cyc < tx_e + FRAME20)
                exp_tx = tx_frame[(cyc - tx_e) / B];
            chk("tx_line", TX, exp_tx);
            exp_snt = tx_valid && (cyc >= tx_e + FRAME20);
            if (!(tx_valid && cyc >= tx_e + FRAME20 && cyc <= tx_e + FRAME20 + 2))
                chk("cmd_snt", cmd_snt, exp_snt);
            d = cyc - rx_s;
            if (!rx_valid) begin
                exp_rdy = 1'b0;
                exp_resp = rx_prev;
                skip_rdy = 1'b0;
                skip_resp = 1'b0;
            end else begin
                skip_resp = (d >= RDY_NOM - 4) && (d <= RDY_NOM + 5);
                skip_rdy  = skip_resp || (d <= 4);
                exp_rdy   = (d > RDY_NOM + 5) && !(tx_valid && tx_e > rx_s + RDY_NOM + 5);
                exp_resp  = (d > RDY_NOM + 5) ? rx_byte : rx_prev;
            end
            if (!skip_rdy) chk("resp_rdy", resp_rdy, exp_rdy);
            if (!skip_resp) chk("resp", resp, exp_resp);
        end
        if (cmd_snt && !prev_snt) rise_cnt++;
        prev_snt = cmd_snt;
    end

    // Loopback UART receiver decoding TX into got_q and checking it against exp_q
    initial begin
        bit         aborted;
        logic [7:0] b;
        logic       start_s, stop_s;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                aborted = 1'b0;
                b = 8'h00;
                for (int i = 0; i < B / 2 && !aborted; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                end
                start_s = TX;
                for (int k = 0; k < 8 && !aborted; k++) begin
                    for (int i = 0; i < B && !aborted; i++) begin
                        @(negedge clk);
                        if (!rst_n) aborted = 1'b1;
                    end
                    b[k] = TX;
                end
                for (int i = 0; i < B && !aborted; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1'b1;
                end
                stop_s = TX;
                if (!aborted) begin
                    got_q.push_back(b);
                    chk("tx_start_bit", start_s, 0);
                    chk("tx_stop_bit", stop_s, 1);
                    chk("tx_byte_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("tx_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_cmd(input logic [15:0] c);
        cmd = c;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        cmd = 16'($urandom);
    endtask

    task automatic drive_rx(input logic [7:0] b);
        rx_prev  = rx_valid ? rx_byte : rx_prev;
        rx_valid = 1'b1;
        rx_s     = cyc;
        rx_byte  = b;
        RX = 1'b0;
        ticks(B);
        for (int k = 0; k < 8; k++) begin
            RX = b[k];
            ticks(B);
        end
        RX = 1'b1;
        ticks(B);
    endtask

    task automatic wait_snt(output int lat);
        int n;
        n = 0;
        while (!cmd_snt && n < FRAME20 + 100) begin
            tick();
            n++;
        end
        chk("cmd_snt_timeout", cmd_snt, 1);
        lat = cyc - tx_e;
    endtask

    task automatic chk_pair(input string name, input logic [7:0] hi, input logic [7:0] lo);
        chk({name, "_count"}, got_q.size(), 2);
        if (got_q.size() >= 2) begin
            chk({name, "_hi"}, got_q[0], hi);
            chk({name, "_lo"}, got_q[1], lo);
        end
        got_q.delete();
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, r0, off;
        logic [15:0] c;
        logic [7:0]  b;

        ticks(5);
        rst_n = 1'b1;
        ticks(5);

        r0 = rise_cnt;
        send_cmd(move_cmd(8'h3F, 4'h3));
        ticks(5 * B);
        cmd = CAL_GYRO;
        snd_cmd = 1'b1;
        tick();
        snd_cmd = 1'b0;
        wait_snt(lat);
        chk_range("snt_latency_43F3", lat, FRAME20, FRAME20 + 2);
        ticks(2 * B);
        chk_pair("busy_ignored", 8'h43, 8'hF3);
        chk("snt_rises_once", rise_cnt - r0, 1);

        send_cmd(CAL_GYRO);
        wait_snt(lat);
        chk_range("snt_latency_2000", lat, FRAME20, FRAME20 + 2);
        ticks(10);
        chk_pair("cal_gyro", 8'h20, 8'h00);

        drive_rx(POS_ACK);
        ticks(10);
        chk("resp_a5", resp, 8'hA5);
        chk("rdy_a5", resp_rdy, 1);

        fork
            drive_rx(8'h5A);
            begin
                ticks(20);
                chk("rdy_clr_on_start", resp_rdy, 0);
                chk("resp_hold", resp, 8'hA5);
            end
        join
        ticks(10);
        chk("resp_5a", resp, 8'h5A);
        chk("rdy_5a", resp_rdy, 1);

        fork
            send_cmd(16'hF00F);
            drive_rx(POS_ACK);
        join
        wait_snt(lat);
        chk_range("snt_latency_duplex", lat, FRAME20, FRAME20 + 2);
        ticks(10);
        chk_pair("duplex", 8'hF0, 8'h0F);
        chk("resp_duplex", resp, 8'hA5);

        for (int t = 0; t < 2; t++) begin
            c   = 16'($urandom);
            b   = 8'($urandom);
            off = $urandom_range(0, 50);
            fork
                begin
                    send_cmd(c);
                    ticks($urandom_range(10, 19 * B - 60));
                    cmd = ~c;
                    snd_cmd = 1'b1;
                    tick();
                    snd_cmd = 1'b0;
                end
                begin
                    ticks(off);
                    drive_rx(b);
                end
            join
            wait_snt(lat);
            chk_range("snt_latency_rand", lat, FRAME20, FRAME20 + 2);
            ticks(10);
            chk_pair("rand_cmd", c[15:8], c[7:0]);
            chk("resp_rand", resp, b);
        end

        send_cmd(16'($urandom));
        ticks(15 * B);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        rx_prev = 8'h00;
        #1;
        chk("midrst_tx_high", TX, 1);
        ticks(3);
        rst_n = 1'b1;
        ticks(5);
        chk("midrst_cmd_snt", cmd_snt, 0);
        got_q.delete();
        send_cmd(CAL_GYRO);
        wait_snt(lat);
        chk_range("snt_latency_after_rst", lat, FRAME20, FRAME20 + 2);
        ticks(10);
        chk_pair("after_rst", 8'h20, 8'h00);

        chk("tx_bytes_pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
